// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Sequences one CPU load/store onto a byte-addressable data memory.
//   All state updates on the falling edge of CLK (the memory write edge).
//   RST is asynchronous and active-low.
//
//   Optional feature macro: MISALIGNED_SPLIT_EN
//     defined   : misaligned half/word accesses are split into byte accesses
//     undefined : misaligned accesses complete with Err=1 and touch no memory
//
// Ports
//   CLK, RST            clock (falling edge active), async active-low reset
//   Req                 access request, sampled only while idle
//   IsStore             1 = store, 0 = load
//   Funct3              RV32 width/sign code
//   Addr, WData         byte address, right-aligned store data
//   Busy                high whenever the FSM is not idle
//   Done                one-cycle completion pulse
//   RData               extended load result, valid with Done
//   Err                 valid with Done, 1 = access rejected
//   DataAddr/DataSize   memory address and size (00 byte, 01 half, 10 word)
//   DataIn, WE          memory write data and write enable
//   MemRData            combinational memory read data
//   DbgState            current FSM state (IDLE=0, ACCESS=1, SPLIT=2, DONE=3)
//
// Handshake: a request is accepted on the falling edge where Req=1 and the
// unit is idle (Busy=0). Req while Busy=1 is ignored. Exactly one Done pulse
// follows each accepted request unless reset intervenes.
module mem_access_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        IsStore,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        Err,
  output logic [31:0] DataAddr,
  output logic [1:0]  DataSize,
  output logic [31:0] DataIn,
  input  logic [31:0] MemRData,
  output logic        WE,
  output logic [1:0]  DbgState
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
`ifdef MISALIGNED_SPLIT_EN
    SPLIT  = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] raw_q;     // load data, zero-extended, before sign handling
`ifdef MISALIGNED_SPLIT_EN
  logic [1:0]  cnt_q;     // byte index inside a split access
  logic [1:0]  cnt_last;
`endif

  // Request decode, only meaningful in IDLE.
  logic f3_ok, misal, accept;

  always_comb begin
    if (IsStore) f3_ok = (Funct3 <= 3'd2);
    else         f3_ok = (Funct3 != 3'd3) && (Funct3 != 3'd6) && (Funct3 != 3'd7);
    misal  = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
             ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
    accept = (state_q == IDLE) && Req;
  end

`ifdef MISALIGNED_SPLIT_EN
  assign cnt_last = funct3_q[0] ? 2'd1 : 2'd3;
`endif

  // State register
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and outputs
  always_comb begin
    state_d  = state_q;
    Busy     = (state_q != IDLE);
    Done     = 1'b0;
    Err      = 1'b0;
    RData    = 32'd0;
    DataAddr = 32'd0;
    DataSize = 2'b00;
    DataIn   = 32'd0;
    WE       = 1'b0;
    DbgState = state_q;
    case (state_q)
      IDLE: begin
        if (Req) begin
          if (!f3_ok) state_d = DONE;
          else if (misal) begin
`ifdef MISALIGNED_SPLIT_EN
            state_d = SPLIT;
`else
            state_d = DONE;
`endif
          end
          else state_d = ACCESS;
        end
      end
      ACCESS: begin
        DataAddr = addr_q;
        DataSize = funct3_q[1:0];
        DataIn   = wdata_q;
        WE       = is_store_q;
        state_d  = DONE;
      end
`ifdef MISALIGNED_SPLIT_EN
      SPLIT: begin
        DataAddr = addr_q + {30'd0, cnt_q};
        DataSize = 2'b00;
        DataIn   = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
        WE       = is_store_q;
        if (cnt_q == cnt_last) state_d = DONE;
      end
`endif
      DONE: begin
        Done    = 1'b1;
        Err     = err_q;
        state_d = IDLE;
        if (!err_q && !is_store_q) begin
          case (funct3_q)
            3'b000:  RData = {{24{raw_q[7]}}, raw_q[7:0]};
            3'b001:  RData = {{16{raw_q[15]}}, raw_q[15:0]};
            3'b100:  RData = {24'd0, raw_q[7:0]};
            3'b101:  RData = {16'd0, raw_q[15:0]};
            default: RData = raw_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Captured request and load data
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      raw_q      <= 32'd0;
`ifdef MISALIGNED_SPLIT_EN
      cnt_q      <= 2'd0;
`endif
    end else begin
      if (accept) begin
        is_store_q <= IsStore;
        funct3_q   <= Funct3;
        addr_q     <= Addr;
        wdata_q    <= WData;
        raw_q      <= 32'd0;
`ifdef MISALIGNED_SPLIT_EN
        err_q      <= !f3_ok;
        cnt_q      <= 2'd0;
`else
        err_q      <= !f3_ok || misal;
`endif
      end
      if (state_q == ACCESS && !is_store_q) begin
        case (funct3_q[1:0])
          2'b00:   raw_q <= {24'd0, MemRData[7:0]};
          2'b01:   raw_q <= {16'd0, MemRData[15:0]};
          default: raw_q <= MemRData;
        endcase
      end
`ifdef MISALIGNED_SPLIT_EN
      if (state_q == SPLIT) begin
        if (!is_store_q) raw_q[{cnt_q, 3'b000} +: 8] <= MemRData[7:0];
        cnt_q <= cnt_q + 2'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b1;
  logic        RST;
  logic        Req, IsStore;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WData;
  logic        Busy, Done, Err, WE;
  logic [31:0] RData, DataAddr, DataIn, MemRData;
  logic [1:0]  DataSize, DbgState;

  always #5 CLK = ~CLK;   // falling edges at 5,15,25,...; sampling on rising edges

  mem_access_unit dut (
    .CLK(CLK), .RST(RST), .Req(Req), .IsStore(IsStore), .Funct3(Funct3),
    .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done), .RData(RData),
    .Err(Err), .DataAddr(DataAddr), .DataSize(DataSize), .DataIn(DataIn),
    .MemRData(MemRData), .WE(WE), .DbgState(DbgState)
  );

  // ---------------- bench memory (1 KiB, address bits [9:0]) ----------------
  logic [7:0] mem     [0:1023];
  logic [7:0] exp_mem [0:1023];
  logic [9:0] a0, a1, a2, a3;

  assign a0 = DataAddr[9:0];
  assign a1 = a0 + 10'd1;
  assign a2 = a0 + 10'd2;
  assign a3 = a0 + 10'd3;
  assign MemRData = (DataSize == 2'b00) ? {4{mem[a0]}} :
                    (DataSize == 2'b01) ? {2{mem[a1], mem[a0]}} :
                                          {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(negedge CLK) begin
    if (RST && WE) begin
      mem[a0] <= DataIn[7:0];
      if (DataSize != 2'b00) mem[a1] <= DataIn[15:8];
      if (DataSize == 2'b10) begin
        mem[a2] <= DataIn[23:16];
        mem[a3] <= DataIn[31:24];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [65:0] exp_q[$];   // {size, addr, data} per expected write cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // Every cycle with WE high must match the next expected write.
  always @(posedge CLK) begin
    if (WE === 1'b1) begin
      if (exp_q.size() == 0) check("we_extra", {31'd0, WE}, 32'd0);
      else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        check("wr_size", {30'd0, DataSize}, {30'd0, e[65:64]});
        check("wr_addr", DataAddr, e[63:32]);
        check("wr_data", DataIn, e[31:0]);
      end
    end
  end

  task automatic check_mem(input string tag);
    int diff = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) diff++;
    check(tag, diff, 0);
  endtask

  // ---------------- reference model + driver ----------------
  task automatic run_access(input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic hold_req);
    int n, lat, done_at;
    logic valid, misal, e_err;
    logic [31:0] e_rd, a;
    n     = 1 << f3[1:0];
    valid = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal = valid && ((addr % n) != 0);
    e_err = 1'b0;
    e_rd  = 32'd0;
    if (!valid) begin
      lat = 1; e_err = 1'b1;
    end else if (misal) begin
`ifdef MISALIGNED_SPLIT_EN
      lat = n + 1;
      for (int k = 0; k < n; k++) begin
        a = addr + k;
        if (st) begin
          exp_q.push_back({2'b00, a, 24'd0, wd[8*k +: 8]});
          exp_mem[a[9:0]] = wd[8*k +: 8];
        end else e_rd = e_rd | (32'(exp_mem[a[9:0]]) << (8*k));
      end
`else
      lat = 1; e_err = 1'b1;
`endif
    end else begin
      lat = 2;
      if (st) exp_q.push_back({f3[1:0], addr, wd});
      for (int k = 0; k < n; k++) begin
        a = addr + k;
        if (st) exp_mem[a[9:0]] = wd[8*k +: 8];
        else    e_rd = e_rd | (32'(exp_mem[a[9:0]]) << (8*k));
      end
    end
    // Sign extension for LB/LH when the top loaded bit is set.
    if (valid && !st && !f3[2] && n < 4 && e_rd[8*n-1])
      e_rd = e_rd | ~((32'd1 << (8*n)) - 32'd1);
    if (st || e_err) e_rd = 32'd0;

    @(posedge CLK);
    Req = 1'b1; IsStore = st; Funct3 = f3; Addr = addr; WData = wd;
    @(negedge CLK);
    #1;
    // Scramble inputs so any re-capture while busy is visible.
    Req = hold_req; IsStore = 1'($urandom); Funct3 = 3'($urandom);
    Addr = $urandom; WData = $urandom;
    done_at = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK);
      if (c == 1) check("busy", {31'd0, Busy}, 32'd1);
      if (done_at != 0) begin
        check("post_busy", {31'd0, Busy}, 32'd0);
        check("post_done", {31'd0, Done}, 32'd0);
        check("post_addr", DataAddr, 32'd0);
        check("post_din", DataIn, 32'd0);
        check("post_state", {30'd0, DbgState}, 32'd0);
        break;
      end
      if (Done === 1'b1) begin
        done_at = c;
        Req = 1'b0;
        check("err", {31'd0, Err}, {31'd0, e_err});
        check("rdata", RData, e_rd);
      end
    end
    Req = 1'b0;
    check("latency", done_at, lat);
    check("we_missing", exp_q.size(), 0);
    exp_q.delete();
    check_mem("mem");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rst_addr;
    int rst_wait;
    RST = 1'b0; Req = 1'b0; IsStore = 1'b0; Funct3 = 3'd0; Addr = 32'd0; WData = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    #2;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    check("rst_we", {31'd0, WE}, 32'd0);
    check("rst_rdata", RData, 32'd0);
    check("rst_addr", DataAddr, 32'd0);
    check("rst_size", {30'd0, DataSize}, 32'd0);
    check("rst_din", DataIn, 32'd0);
    check("rst_state", {30'd0, DbgState}, 32'd0);
    #18 RST = 1'b1;

    // LW at 0x10 -> 0x12345678
    mem[16] = 8'h78; mem[17] = 8'h56; mem[18] = 8'h34; mem[19] = 8'h12;
    exp_mem[16] = 8'h78; exp_mem[17] = 8'h56; exp_mem[18] = 8'h34; exp_mem[19] = 8'h12;
    run_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    // LB / LBU of 0x80
    mem[32] = 8'h80; exp_mem[32] = 8'h80;
    run_access(1'b0, 3'b000, 32'h20, 32'h0, 1'b0);
    run_access(1'b0, 3'b100, 32'h20, 32'h0, 1'b0);
    // SH at 0x42, SW at 0x101 (split or rejected), invalid load held Req
    run_access(1'b1, 3'b001, 32'h42, 32'hAABBCCDD, 1'b0);
    run_access(1'b1, 3'b010, 32'h101, 32'h11223344, 1'b0);
    run_access(1'b0, 3'b011, 32'h30, 32'h0, 1'b1);
    run_access(1'b1, 3'b101, 32'h30, 32'h55, 1'b1);
    // Address wrap at the top of the 32-bit space
    run_access(1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run_access(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hCAFE_BEEF, 1'b0);
    run_access(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run_access(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Random accesses
    for (int i = 0; i < 60; i++)
      run_access(1'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 1023),
                 $urandom, 1'($urandom));

    // Reset in the middle of a store
`ifdef MISALIGNED_SPLIT_EN
    rst_addr = 32'h101; rst_wait = 2;
    exp_q.push_back({2'b00, 32'h101, 32'h44});
    exp_q.push_back({2'b00, 32'h102, 32'h33});
    exp_mem[10'h101] = 8'h44;
`else
    rst_addr = 32'h200; rst_wait = 1;
    exp_q.push_back({2'b10, 32'h200, 32'h11223344});
`endif
    @(posedge CLK);
    Req = 1'b1; IsStore = 1'b1; Funct3 = 3'b010; Addr = rst_addr; WData = 32'h11223344;
    @(negedge CLK);
    #1 Req = 1'b0;
    repeat (rst_wait) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("arst_we", {31'd0, WE}, 32'd0);
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_done", {31'd0, Done}, 32'd0);
    check("arst_state", {30'd0, DbgState}, 32'd0);
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK);
      check("arst_no_done", {31'd0, Done}, 32'd0);
    end
    check("arst_we_missing", exp_q.size(), 0);
    check_mem("arst_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
